// File: rtl/address_generator.sv
// Purpose: 6502 program counter owner and address bus driver, including the post-reset vector fetch.
// Latency: address_bus is combinational from the state, pc and selects; pc/core_ready update on the rising edge of clk.
// Backpressure: rdy=0 freezes state, pc and core_ready, and drops any pc_enable/pc_load presented that cycle.
// Ports:
//   clk, res (sync active-low)    clock and reset
//   rdy                           advance enable
//   pc_enable, pc_load            PC increment/load requests, honoured only in RUN; load wins
//   pc_load_value                 jump target
//   address_select                0/3 = pc, 1 = memory_address, 2 = zero page {8'h00, alu_result}
//   memory_address, alu_result    operand address sources
//   data_in                       data bus, captured during the vector fetch
//   address_bus, pc               memory address and current program counter
//   core_ready, vector_fetch      decoder stall release; vector fetch in progress
module address_generator #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [15:0] PC_RESET     = 16'h0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        pc_enable,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    input  logic [1:0]  address_select,
    input  logic [15:0] memory_address,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  data_in,
    output logic [15:0] address_bus,
    output logic [15:0] pc,
    output logic        core_ready,
    output logic        vector_fetch
);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        VEC_LO = 2'd1,
        VEC_HI = 2'd2,
        RUN    = 2'd3
    } state_t;

    // High byte of the vector sits one above the low byte, wrapping within 16 bits.
    localparam logic [15:0] VECTOR_HI_ADDR = RESET_VECTOR + 16'd1;

    state_t state;
    state_t state_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!res) begin
            state <= HOLD;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a one-shot walk through the vector fetch, then RUN forever.
    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:    state_nxt = VEC_LO;
            VEC_LO:  state_nxt = VEC_HI;
            VEC_HI:  state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = HOLD;
        endcase
    end

    // Output logic: address selection is only meaningful once the PC is valid.
    always_comb begin
        address_bus  = RESET_VECTOR;
        vector_fetch = 1'b0;
        case (state)
            HOLD: begin
                address_bus  = RESET_VECTOR;
                vector_fetch = 1'b0;
            end
            VEC_LO: begin
                address_bus  = RESET_VECTOR;
                vector_fetch = 1'b1;
            end
            VEC_HI: begin
                address_bus  = VECTOR_HI_ADDR;
                vector_fetch = 1'b1;
            end
            RUN: begin
                case (address_select)
                    2'd1:    address_bus = memory_address;
                    2'd2:    address_bus = {8'h00, alu_result};
                    default: address_bus = pc;
                endcase
            end
            default: begin
                address_bus  = RESET_VECTOR;
                vector_fetch = 1'b0;
            end
        endcase
    end

    // PC and ready flag. Requests seen while rdy=0 are simply not acted on, never queued.
    always_ff @(posedge clk) begin
        if (!res) begin
            pc         <= PC_RESET;
            core_ready <= 1'b0;
        end else if (rdy) begin
            case (state)
                VEC_LO: pc[7:0] <= data_in;
                VEC_HI: begin
                    pc[15:8]   <= data_in;
                    core_ready <= 1'b1;
                end
                RUN: begin
                    if (pc_load) begin
                        pc <= pc_load_value;
                    end else if (pc_enable) begin
                        pc <= pc + 16'd1;
                    end
                end
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: tb/tb_address_generator.sv
module tb_address_generator;

    logic        clk = 1'b0;
    logic        res;
    logic        rdy;
    logic        pc_enable;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [1:0]  address_select;
    logic [15:0] memory_address;
    logic [7:0]  alu_result;
    logic [7:0]  data_in;
    logic [15:0] address_bus;
    logic [15:0] pc;
    logic        core_ready;
    logic        vector_fetch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: reset vector is 16'h1234 stored little-endian at FFFC/FFFD.
    assign data_in = (address_bus == 16'hFFFC) ? 8'h34 :
                     (address_bus == 16'hFFFD) ? 8'h12 : 8'hEA;

    address_generator dut (
        .clk            (clk),
        .res            (res),
        .rdy            (rdy),
        .pc_enable      (pc_enable),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .address_select (address_select),
        .memory_address (memory_address),
        .alu_result     (alu_result),
        .data_in        (data_in),
        .address_bus    (address_bus),
        .pc             (pc),
        .core_ready     (core_ready),
        .vector_fetch   (vector_fetch)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_load       = 1'b1;
        pc_load_value = v;
        tick();
        pc_load       = 1'b0;
        #1;
    endtask

    task automatic run_fetch(input string tag);
        chk({tag, "_hold_addr"}, address_bus, 16'hFFFC);
        chk({tag, "_hold_vf"}, {15'd0, vector_fetch}, 16'd0);
        tick();
        chk({tag, "_lo_addr"}, address_bus, 16'hFFFC);
        chk({tag, "_lo_vf"}, {15'd0, vector_fetch}, 16'd1);
        chk({tag, "_lo_cr"}, {15'd0, core_ready}, 16'd0);
        tick();
        chk({tag, "_hi_addr"}, address_bus, 16'hFFFD);
        chk({tag, "_hi_vf"}, {15'd0, vector_fetch}, 16'd1);
        chk({tag, "_hi_pclo"}, pc, 16'h0034);
    endtask

    initial begin
        res            = 1'b0;
        rdy            = 1'b1;
        pc_enable      = 1'b0;
        pc_load        = 1'b0;
        pc_load_value  = 16'h0000;
        address_select = 2'd0;
        memory_address = 16'h0000;
        alu_result     = 8'h00;

        for (int i = 0; i < 3; i++) tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_cr", {15'd0, core_ready}, 16'd0);

        // Release reset, walk the vector fetch with a stall in VEC_HI.
        res = 1'b1;
        #1;
        run_fetch("fetch");
        rdy       = 1'b0;
        pc_enable = 1'b1;
        tick();
        chk("stall_addr", address_bus, 16'hFFFD);
        chk("stall_pc", pc, 16'h0034);
        chk("stall_cr", {15'd0, core_ready}, 16'd0);
        chk("stall_vf", {15'd0, vector_fetch}, 16'd1);
        rdy = 1'b1;
        tick();
        pc_enable = 1'b0;
        #1;
        chk("run_cr", {15'd0, core_ready}, 16'd1);
        chk("run_vf", {15'd0, vector_fetch}, 16'd0);
        chk("run_pc", pc, 16'h1234);
        chk("run_addr", address_bus, 16'h1234);
        tick();
        chk("idle_pc", pc, 16'h1234);

        // Load priority over increment.
        load_pc(16'h0200);
        chk("ld_pc", pc, 16'h0200);
        pc_load       = 1'b1;
        pc_enable     = 1'b1;
        pc_load_value = 16'hC000;
        tick();
        pc_load   = 1'b0;
        pc_enable = 1'b0;
        #1;
        chk("prio_pc", pc, 16'hC000);
        tick();
        chk("prio_hold", pc, 16'hC000);

        // Increment with 16-bit wrap.
        load_pc(16'hFFFE);
        pc_enable = 1'b1;
        tick();
        chk("inc_ffff", pc, 16'hFFFF);
        tick();
        chk("inc_0000", pc, 16'h0000);
        chk("inc_addr", address_bus, 16'h0000);
        tick();
        chk("inc_0001", pc, 16'h0001);
        pc_enable = 1'b0;

        // Address mux.
        load_pc(16'h0300);
        memory_address = 16'h4567;
        alu_result     = 8'h05;
        address_select = 2'd0; #1; chk("mux0", address_bus, 16'h0300);
        address_select = 2'd1; #1; chk("mux1", address_bus, 16'h4567);
        address_select = 2'd2; #1; chk("mux2", address_bus, 16'h0005);
        address_select = 2'd3; #1; chk("mux3", address_bus, 16'h0300);
        address_select = 2'd0;

        // Stall in RUN drops a load request.
        rdy           = 1'b0;
        pc_load       = 1'b1;
        pc_load_value = 16'hBEEF;
        tick();
        chk("runstall_pc", pc, 16'h0300);
        rdy     = 1'b1;
        pc_load = 1'b0;
        tick();
        chk("runstall_drop", pc, 16'h0300);

        // Reset mid-operation beats a pending increment.
        load_pc(16'h8000);
        res       = 1'b0;
        pc_enable = 1'b1;
        tick();
        chk("mrst_pc", pc, 16'h0000);
        chk("mrst_cr", {15'd0, core_ready}, 16'd0);
        chk("mrst_addr", address_bus, 16'hFFFC);
        res       = 1'b1;
        pc_enable = 1'b0;
        #1;
        run_fetch("refetch");
        tick();
        chk("refetch_pc", pc, 16'h1234);
        chk("refetch_cr", {15'd0, core_ready}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
